// File: rtl/debug_ctrl_pkg.sv
// debug_ctrl_pkg -- shared encodings and parameter defaults for cpu_debug_ctrl.
// Revision 1.0
`default_nettype none

package debug_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH  = 4;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_CYCLE_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_RUN   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_TIMEOUT   = 2'd1,
    ST_RANGE_ERR = 2'd2
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_WRITE   = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RUN     = 3'd5,
    S_RESP    = 3'd6
  } state_e;

endpackage

`default_nettype wire

// File: rtl/cpu_debug_ctrl_if.sv
// cpu_debug_ctrl_if -- command, RAM, CPU-control and response signals of cpu_debug_ctrl.
// Revision 1.0
`default_nettype none

interface cpu_debug_ctrl_if
  import debug_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int CYCLE_WIDTH = DEF_CYCLE_WIDTH
);

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_op;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic [ADDR_WIDTH-1:0]  cmd_addr_end;
  logic [DATA_WIDTH-1:0]  cmd_data;
  logic [CYCLE_WIDTH-1:0] cmd_max_cycles;

  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic [DATA_WIDTH-1:0]  mem_rdata;

  logic                   cpu_run;
  logic                   cpu_halt;

  logic                   rsp_valid;
  logic [1:0]             rsp_status;
  logic [DATA_WIDTH-1:0]  rsp_data;
  logic [CYCLE_WIDTH-1:0] rsp_cycles;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_addr_end, cmd_data, cmd_max_cycles,
    input  cmd_ready,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  cpu_run,
    output cpu_halt,
    input  rsp_valid, rsp_status, rsp_data, rsp_cycles
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_addr_end, cmd_data, cmd_max_cycles,
    output cmd_ready,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output cpu_run,
    input  cpu_halt,
    output rsp_valid, rsp_status, rsp_data, rsp_cycles
  );

endinterface

`default_nettype wire

// File: rtl/dbg_cycle_counter.sv
// dbg_cycle_counter -- run cycle counter; hit_o flags the cycle whose increment reaches limit_i.
// Revision 1.0
`default_nettype none

module dbg_cycle_counter
  import debug_ctrl_pkg::*;
#(
  parameter int CYCLE_WIDTH = DEF_CYCLE_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic [CYCLE_WIDTH-1:0] limit_i,
  output logic [CYCLE_WIDTH-1:0] count_o,
  output logic                   hit_o
);

  logic [CYCLE_WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + CYCLE_WIDTH'(1);
    end
  end

  assign count_o = count_q;
  assign hit_o   = enable_i && ((count_q + CYCLE_WIDTH'(1)) == limit_i);

endmodule

`default_nettype wire

// File: rtl/cpu_debug_ctrl.sv
// cpu_debug_ctrl -- debug command FSM: RAM clear/write/read and bounded CPU run.
// Revision 1.0; define DBG_RUN_TIMEOUT_EN to end RUN with TIMEOUT at cmd_max_cycles.
`default_nettype none

module cpu_debug_ctrl
  import debug_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int CYCLE_WIDTH = DEF_CYCLE_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  cpu_debug_ctrl_if.slave bus
);

  state_e                 state_q, state_d;
  status_e                status_q, status_d;
  logic                   alive_q;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d, end_q, end_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CYCLE_WIDTH-1:0] max_q, max_d, cycles_q, cycles_d;
  logic [CYCLE_WIDTH-1:0] cnt;
  logic                   cnt_clear, hit, ready, accept, run;
  logic                   rsp_load;
  status_e                rsp_st;
  logic [DATA_WIDTH-1:0]  rsp_dat;
  logic [CYCLE_WIDTH-1:0] rsp_cyc;

  // alive_q keeps cmd_ready low until the first edge after reset releases
  assign ready  = alive_q && (state_q == S_IDLE);
  assign accept = bus.cmd_valid && ready;
  assign run    = (state_q == S_RUN);

  dbg_cycle_counter #(.CYCLE_WIDTH(CYCLE_WIDTH)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (cnt_clear),
    .enable_i (run),
    .limit_i  (max_q),
    .count_o  (cnt),
    .hit_o    (hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      status_q <= ST_OK;
      alive_q  <= 1'b0;
      addr_q   <= '0;
      end_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      max_q    <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      alive_q  <= 1'b1;
      addr_q   <= addr_d;
      end_q    <= end_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      max_q    <= max_d;
      cycles_q <= cycles_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    addr_d    = addr_q;
    end_d     = end_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    max_d     = max_q;
    cycles_d  = cycles_q;
    cnt_clear = 1'b0;
    rsp_load  = 1'b0;
    rsp_st    = ST_OK;
    rsp_dat   = '0;
    rsp_cyc   = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = bus.cmd_addr;
          end_d   = bus.cmd_addr_end;
          max_d   = bus.cmd_max_cycles;
          wdata_d = '0;
          case (op_e'(bus.cmd_op))
            OP_CLEAR: begin
              if (bus.cmd_addr > bus.cmd_addr_end) begin
                rsp_load = 1'b1;
                rsp_st   = ST_RANGE_ERR;
              end else begin
                state_d = S_CLEAR;
              end
            end
            OP_WRITE: begin
              wdata_d = bus.cmd_data;
              state_d = S_WRITE;
            end
            OP_READ:  state_d = S_RD_ADDR;
            OP_RUN: begin
              if (bus.cpu_halt) begin
                rsp_load = 1'b1;
              end else begin
                cnt_clear = 1'b1;
                state_d   = S_RUN;
              end
            end
            default:  state_d = S_IDLE;
          endcase
        end
      end
      // stopping on equality rather than incrementing past the end avoids wrap
      S_CLEAR: begin
        if (addr_q == end_q) begin
          rsp_load = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      S_WRITE:   rsp_load = 1'b1;
      S_RD_ADDR: state_d  = S_RD_WAIT;
      S_RD_WAIT: begin
        rsp_load = 1'b1;
        rsp_dat  = bus.mem_rdata;
      end
      S_RUN: begin
        if (bus.cpu_halt) begin
          rsp_load = 1'b1;
          rsp_cyc  = cnt + CYCLE_WIDTH'(1);
        end
`ifdef DBG_RUN_TIMEOUT_EN
        else if (hit) begin
          rsp_load = 1'b1;
          rsp_st   = ST_TIMEOUT;
          rsp_cyc  = max_q;
        end
`endif
      end
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (rsp_load) begin
      state_d  = S_RESP;
      status_d = rsp_st;
      rdata_d  = rsp_dat;
      cycles_d = rsp_cyc;
    end
  end

`ifndef DBG_RUN_TIMEOUT_EN
  logic unused_hit;
  assign unused_hit = hit;
`endif

  assign bus.cmd_ready  = ready;
  assign bus.mem_we     = (state_q == S_CLEAR) || (state_q == S_WRITE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.cpu_run    = run;
  assign bus.rsp_valid  = (state_q == S_RESP);
  assign bus.rsp_status = status_q;
  assign bus.rsp_data   = rdata_q;
  assign bus.rsp_cycles = cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_debug_ctrl.sv
// ============================================================================
// Module      : tb_cpu_debug_ctrl
// Description : Directed self-checking bench for cpu_debug_ctrl with a
//               1-cycle-read RAM model.
// Revision    : 1.1
// ============================================================================
`default_nettype none

module tb_cpu_debug_ctrl;
    import debug_ctrl_pkg::*;

    logic        clk;
    logic        reset;

    int          r_n_cmp = 0;
    int          r_n_bad = 0;
    int          r_lat;
    int          r_we_cnt;
    int          r_run_cnt;
    bit          r_got;
    logic [1:0]  r_st;
    logic [7:0]  r_dat;
    logic [15:0] r_cyc;
    logic [7:0]  r_mem [0:15];

    cpu_debug_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .CYCLE_WIDTH(16)) bus ();

    cpu_debug_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .CYCLE_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_we) r_mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= r_mem[bus.mem_addr];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed time limit reached, required completion");
        $fatal(1);
    end

    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] e,
                         input logic [7:0] d, input logic [15:0] mx);
        @(negedge clk);
        r_n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            r_n_bad++;
            $error("FAIL cmd_ready: observed 0x%0h expected 0x1", bus.cmd_ready);
        end
        bus.cmd_valid      = 1'b1;
        bus.cmd_op         = op;
        bus.cmd_addr       = a;
        bus.cmd_addr_end   = e;
        bus.cmd_data       = d;
        bus.cmd_max_cycles = mx;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        r_lat = 0; r_we_cnt = 0; r_run_cnt = 0; r_got = 1'b0;
    endtask

    task automatic wait_rsp(input int halt_after, input int budget);
        r_got = 1'b0;
        for (int i = 1; i <= budget && !r_got; i++) begin
            @(negedge clk);
            r_lat++;
            if (bus.mem_we) r_we_cnt++;
            if (bus.cpu_run) begin
                r_run_cnt++;
                if (r_run_cnt == halt_after) bus.cpu_halt = 1'b1;
            end
            if (bus.rsp_valid) begin
                r_got = 1'b1;
                r_st  = bus.rsp_status;
                r_dat = bus.rsp_data;
                r_cyc = bus.rsp_cycles;
            end
        end
    endtask

    initial begin
        reset              = 1'b0;
        bus.cmd_valid      = 1'b0;
        bus.cmd_op         = 2'd0;
        bus.cmd_addr       = 4'd0;
        bus.cmd_addr_end   = 4'd0;
        bus.cmd_data       = 8'd0;
        bus.cmd_max_cycles = 16'd0;
        bus.cpu_halt       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        r_n_cmp++; if (bus.cmd_ready !== 1'b0) begin r_n_bad++; $error("FAIL rst_ready: observed 0x%0h expected 0x0", bus.cmd_ready); end
        r_n_cmp++; if (bus.cpu_run !== 1'b0) begin r_n_bad++; $error("FAIL rst_run: observed 0x%0h expected 0x0", bus.cpu_run); end
        r_n_cmp++; if (bus.mem_we !== 1'b0) begin r_n_bad++; $error("FAIL rst_we: observed 0x%0h expected 0x0", bus.mem_we); end
        r_n_cmp++; if (bus.rsp_valid !== 1'b0) begin r_n_bad++; $error("FAIL rst_rspv: observed 0x%0h expected 0x0", bus.rsp_valid); end
        r_n_cmp++; if (bus.rsp_status !== 2'd0) begin r_n_bad++; $error("FAIL rst_status: observed 0x%0h expected 0x0", bus.rsp_status); end
        r_n_cmp++; if (bus.rsp_data !== 8'd0) begin r_n_bad++; $error("FAIL rst_data: observed 0x%0h expected 0x0", bus.rsp_data); end
        r_n_cmp++; if (bus.rsp_cycles !== 16'd0) begin r_n_bad++; $error("FAIL rst_cycles: observed 0x%0h expected 0x0", bus.rsp_cycles); end
        r_n_cmp++; if (bus.mem_addr !== 4'd0) begin r_n_bad++; $error("FAIL rst_addr: observed 0x%0h expected 0x0", bus.mem_addr); end
        r_n_cmp++; if (bus.mem_wdata !== 8'd0) begin r_n_bad++; $error("FAIL rst_wdata: observed 0x%0h expected 0x0", bus.mem_wdata); end

        @(negedge clk);
        reset = 1'b1;
        #1;
        r_n_cmp++; if (bus.cmd_ready !== 1'b0) begin r_n_bad++; $error("FAIL ready_before_edge: observed 0x%0h expected 0x0", bus.cmd_ready); end
        @(posedge clk);
        #1;
        r_n_cmp++; if (bus.cmd_ready !== 1'b1) begin r_n_bad++; $error("FAIL ready_first_edge: observed 0x%0h expected 0x1", bus.cmd_ready); end

        for (int i = 0; i < 16; i++) begin
            issue(OP_WRITE, 4'(i), 4'd0, 8'hFF, 16'd0);
            wait_rsp(0, 10);
            r_n_cmp++; if (r_got !== 1'b1) begin r_n_bad++; $error("FAIL pre_got: observed 0x%0h expected 0x1", r_got); end
            r_n_cmp++; if (r_we_cnt !== 1) begin r_n_bad++; $error("FAIL pre_we: observed 0x%0h expected 0x1", r_we_cnt); end
        end

        issue(OP_WRITE, 4'd3, 4'd0, 8'hA5, 16'd0);
        wait_rsp(0, 10);
        r_n_cmp++; if (r_got !== 1'b1) begin r_n_bad++; $error("FAIL wr_got: observed 0x%0h expected 0x1", r_got); end
        r_n_cmp++; if (r_st !== 2'd0) begin r_n_bad++; $error("FAIL wr_status: observed 0x%0h expected 0x0", r_st); end
        r_n_cmp++; if (r_we_cnt !== 1) begin r_n_bad++; $error("FAIL wr_we: observed 0x%0h expected 0x1", r_we_cnt); end
        r_n_cmp++; if (r_mem[3] !== 8'hA5) begin r_n_bad++; $error("FAIL wr_mem3: observed 0x%0h expected 0xa5", r_mem[3]); end

        issue(OP_READ, 4'd3, 4'd0, 8'h00, 16'd0);
        wait_rsp(0, 10);
        r_n_cmp++; if (r_got !== 1'b1) begin r_n_bad++; $error("FAIL rd_got: observed 0x%0h expected 0x1", r_got); end
        r_n_cmp++; if (r_lat !== 3) begin r_n_bad++; $error("FAIL rd_lat: observed 0x%0h expected 0x3", r_lat); end
        r_n_cmp++; if (r_st !== 2'd0) begin r_n_bad++; $error("FAIL rd_status: observed 0x%0h expected 0x0", r_st); end
        r_n_cmp++; if (r_dat !== 8'hA5) begin r_n_bad++; $error("FAIL rd_data: observed 0x%0h expected 0xa5", r_dat); end
        r_n_cmp++; if (r_we_cnt !== 0) begin r_n_bad++; $error("FAIL rd_we: observed 0x%0h expected 0x0", r_we_cnt); end
        @(negedge clk);
        r_n_cmp++; if (bus.rsp_valid !== 1'b0) begin r_n_bad++; $error("FAIL rsp_pulse: observed 0x%0h expected 0x0", bus.rsp_valid); end
        r_n_cmp++; if (bus.rsp_data !== 8'hA5) begin r_n_bad++; $error("FAIL rsp_hold: observed 0x%0h expected 0xa5", bus.rsp_data); end

        issue(OP_CLEAR, 4'd2, 4'd5, 8'h00, 16'd0);
        wait_rsp(0, 20);
        r_n_cmp++; if (r_got !== 1'b1) begin r_n_bad++; $error("FAIL clr_got: observed 0x%0h expected 0x1", r_got); end
        r_n_cmp++; if (r_st !== 2'd0) begin r_n_bad++; $error("FAIL clr_status: observed 0x%0h expected 0x0", r_st); end
        r_n_cmp++; if (r_we_cnt !== 4) begin r_n_bad++; $error("FAIL clr_we: observed 0x%0h expected 0x4", r_we_cnt); end
        r_n_cmp++; if (r_mem[1] !== 8'hFF) begin r_n_bad++; $error("FAIL clr_mem1: observed 0x%0h expected 0xff", r_mem[1]); end
        r_n_cmp++; if (r_mem[2] !== 8'h00) begin r_n_bad++; $error("FAIL clr_mem2: observed 0x%0h expected 0x0", r_mem[2]); end
        r_n_cmp++; if (r_mem[3] !== 8'h00) begin r_n_bad++; $error("FAIL clr_mem3: observed 0x%0h expected 0x0", r_mem[3]); end
        r_n_cmp++; if (r_mem[4] !== 8'h00) begin r_n_bad++; $error("FAIL clr_mem4: observed 0x%0h expected 0x0", r_mem[4]); end
        r_n_cmp++; if (r_mem[5] !== 8'h00) begin r_n_bad++; $error("FAIL clr_mem5: observed 0x%0h expected 0x0", r_mem[5]); end
        r_n_cmp++; if (r_mem[6] !== 8'hFF) begin r_n_bad++; $error("FAIL clr_mem6: observed 0x%0h expected 0xff", r_mem[6]); end

        issue(OP_READ, 4'd6, 4'd0, 8'h00, 16'd0);
        wait_rsp(0, 10);
        r_n_cmp++; if (r_dat !== 8'hFF) begin r_n_bad++; $error("FAIL rd6_data: observed 0x%0h expected 0xff", r_dat); end

        issue(OP_CLEAR, 4'd6, 4'd2, 8'h00, 16'd0);
        wait_rsp(0, 20);
        r_n_cmp++; if (r_got !== 1'b1) begin r_n_bad++; $error("FAIL rng_got: observed 0x%0h expected 0x1", r_got); end
        r_n_cmp++; if (r_st !== 2'd2) begin r_n_bad++; $error("FAIL rng_status: observed 0x%0h expected 0x2", r_st); end
        r_n_cmp++; if (r_we_cnt !== 0) begin r_n_bad++; $error("FAIL rng_we: observed 0x%0h expected 0x0", r_we_cnt); end

        issue(OP_CLEAR, 4'd7, 4'd7, 8'h00, 16'd0);
        wait_rsp(0, 20);
        r_n_cmp++; if (r_st !== 2'd0) begin r_n_bad++; $error("FAIL one_status: observed 0x%0h expected 0x0", r_st); end
        r_n_cmp++; if (r_we_cnt !== 1) begin r_n_bad++; $error("FAIL one_we: observed 0x%0h expected 0x1", r_we_cnt); end
        r_n_cmp++; if (r_mem[7] !== 8'h00) begin r_n_bad++; $error("FAIL one_mem7: observed 0x%0h expected 0x0", r_mem[7]); end
        r_n_cmp++; if (r_mem[8] !== 8'hFF) begin r_n_bad++; $error("FAIL one_mem8: observed 0x%0h expected 0xff", r_mem[8]); end

        issue(OP_RUN, 4'd0, 4'd0, 8'h00, 16'd0);
        wait_rsp(10, 50);
        bus.cpu_halt = 1'b0;
        r_n_cmp++; if (r_got !== 1'b1) begin r_n_bad++; $error("FAIL run_got: observed 0x%0h expected 0x1", r_got); end
        r_n_cmp++; if (r_st !== 2'd0) begin r_n_bad++; $error("FAIL run_status: observed 0x%0h expected 0x0", r_st); end
        r_n_cmp++; if (r_cyc !== 16'd10) begin r_n_bad++; $error("FAIL run_cycles: observed 0x%0h expected 0xa", r_cyc); end
        r_n_cmp++; if (r_run_cnt !== 10) begin r_n_bad++; $error("FAIL run_runcnt: observed 0x%0h expected 0xa", r_run_cnt); end
        r_n_cmp++; if (bus.cpu_run !== 1'b0) begin r_n_bad++; $error("FAIL run_off: observed 0x%0h expected 0x0", bus.cpu_run); end

        bus.cpu_halt = 1'b1;
        issue(OP_RUN, 4'd0, 4'd0, 8'h00, 16'd0);
        wait_rsp(0, 10);
        bus.cpu_halt = 1'b0;
        r_n_cmp++; if (r_lat !== 1) begin r_n_bad++; $error("FAIL pre_halt_lat: observed 0x%0h expected 0x1", r_lat); end
        r_n_cmp++; if (r_cyc !== 16'd0) begin r_n_bad++; $error("FAIL pre_halt_cycles: observed 0x%0h expected 0x0", r_cyc); end
        r_n_cmp++; if (r_st !== 2'd0) begin r_n_bad++; $error("FAIL pre_halt_status: observed 0x%0h expected 0x0", r_st); end
        r_n_cmp++; if (r_run_cnt !== 0) begin r_n_bad++; $error("FAIL pre_halt_run: observed 0x%0h expected 0x0", r_run_cnt); end

`ifdef DBG_RUN_TIMEOUT_EN
        issue(OP_RUN, 4'd0, 4'd0, 8'h00, 16'd20);
        wait_rsp(0, 100);
        r_n_cmp++; if (r_got !== 1'b1) begin r_n_bad++; $error("FAIL to_got: observed 0x%0h expected 0x1", r_got); end
        r_n_cmp++; if (r_st !== 2'd1) begin r_n_bad++; $error("FAIL to_status: observed 0x%0h expected 0x1", r_st); end
        r_n_cmp++; if (r_cyc !== 16'd20) begin r_n_bad++; $error("FAIL to_cycles: observed 0x%0h expected 0x14", r_cyc); end
        r_n_cmp++; if (r_run_cnt !== 20) begin r_n_bad++; $error("FAIL to_runcnt: observed 0x%0h expected 0x14", r_run_cnt); end

        issue(OP_RUN, 4'd0, 4'd0, 8'h00, 16'd5);
        wait_rsp(5, 50);
        bus.cpu_halt = 1'b0;
        r_n_cmp++; if (r_st !== 2'd0) begin r_n_bad++; $error("FAIL tie_status: observed 0x%0h expected 0x0", r_st); end
        r_n_cmp++; if (r_cyc !== 16'd5) begin r_n_bad++; $error("FAIL tie_cycles: observed 0x%0h expected 0x5", r_cyc); end
`else
        issue(OP_RUN, 4'd0, 4'd0, 8'h00, 16'd20);
        wait_rsp(0, 100);
        r_n_cmp++; if (r_got !== 1'b0) begin r_n_bad++; $error("FAIL nto_got: observed 0x%0h expected 0x0", r_got); end
        r_n_cmp++; if (bus.cpu_run !== 1'b1) begin r_n_bad++; $error("FAIL nto_run: observed 0x%0h expected 0x1", bus.cpu_run); end
        r_n_cmp++; if (r_run_cnt !== 100) begin r_n_bad++; $error("FAIL nto_runcnt: observed 0x%0h expected 0x64", r_run_cnt); end
        bus.cpu_halt = 1'b1;
        wait_rsp(0, 5);
        bus.cpu_halt = 1'b0;
        r_n_cmp++; if (r_got !== 1'b1) begin r_n_bad++; $error("FAIL nto_end_got: observed 0x%0h expected 0x1", r_got); end
        r_n_cmp++; if (r_st !== 2'd0) begin r_n_bad++; $error("FAIL nto_end_status: observed 0x%0h expected 0x0", r_st); end
        r_n_cmp++; if (r_cyc !== 16'd100) begin r_n_bad++; $error("FAIL nto_end_cycles: observed 0x%0h expected 0x64", r_cyc); end
`endif

        issue(OP_CLEAR, 4'd0, 4'd10, 8'h00, 16'd0);
        for (int i = 0; i < 20 && !(bus.mem_we && bus.mem_addr == 4'd4); i++) @(negedge clk);
        r_n_cmp++; if (bus.mem_addr !== 4'd4) begin r_n_bad++; $error("FAIL mid_addr4: observed 0x%0h expected 0x4", bus.mem_addr); end
        reset = 1'b0;
        #1;
        r_n_cmp++; if (bus.cpu_run !== 1'b0) begin r_n_bad++; $error("FAIL mid_run: observed 0x%0h expected 0x0", bus.cpu_run); end
        r_n_cmp++; if (bus.mem_we !== 1'b0) begin r_n_bad++; $error("FAIL mid_we: observed 0x%0h expected 0x0", bus.mem_we); end
        r_n_cmp++; if (bus.cmd_ready !== 1'b0) begin r_n_bad++; $error("FAIL mid_ready: observed 0x%0h expected 0x0", bus.cmd_ready); end
        r_n_cmp++; if (bus.rsp_valid !== 1'b0) begin r_n_bad++; $error("FAIL mid_rspv: observed 0x%0h expected 0x0", bus.rsp_valid); end
        r_n_cmp++; if (bus.mem_addr !== 4'd0) begin r_n_bad++; $error("FAIL mid_addr: observed 0x%0h expected 0x0", bus.mem_addr); end
        r_n_cmp++; if (bus.rsp_cycles !== 16'd0) begin r_n_bad++; $error("FAIL mid_cycles: observed 0x%0h expected 0x0", bus.rsp_cycles); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        r_n_cmp++; if (bus.cmd_ready !== 1'b1) begin r_n_bad++; $error("FAIL mid_idle: observed 0x%0h expected 0x1", bus.cmd_ready); end
        r_n_cmp++; if (r_mem[9] !== 8'hFF) begin r_n_bad++; $error("FAIL mid_mem9: observed 0x%0h expected 0xff", r_mem[9]); end

        issue(OP_READ, 4'd9, 4'd0, 8'h00, 16'd0);
        wait_rsp(0, 10);
        r_n_cmp++; if (r_got !== 1'b1) begin r_n_bad++; $error("FAIL post_got: observed 0x%0h expected 0x1", r_got); end
        r_n_cmp++; if (r_lat !== 3) begin r_n_bad++; $error("FAIL post_lat: observed 0x%0h expected 0x3", r_lat); end
        r_n_cmp++; if (r_dat !== 8'hFF) begin r_n_bad++; $error("FAIL post_data: observed 0x%0h expected 0xff", r_dat); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", r_n_cmp, r_n_bad);
        $finish;
    end

endmodule

`default_nettype wire
